// File: rtl/multicycle_maindec_if.sv
// Control bus between the instruction register/memories and the multi-cycle main decoder.
// The slave modport is the decoder side; master is the datapath/memory side.
interface multicycle_maindec_if #(
    parameter int unsigned OP_W = 11,
    parameter int unsigned ES_W = 4
);
    logic [OP_W-1:0] Op;
    logic            imem_ready;
    logic            mem_ready;
    logic            irq;

    logic            Reg2Loc;
    logic [1:0]      ALUSrc;
    logic            MemtoReg;
    logic            RegWrite;
    logic            MemRead;
    logic            MemWrite;
    logic            Branch;
    logic [1:0]      ALUOp;
    logic            ERet;
    logic            PCWrite;
    logic            IRWrite;
    logic            Exc;
    logic [ES_W-1:0] EStatus;

    modport master (
        output Op, imem_ready, mem_ready, irq,
        input  Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
               ERet, PCWrite, IRWrite, Exc, EStatus
    );

    modport slave (
        input  Op, imem_ready, mem_ready, irq,
        output Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
               ERet, PCWrite, IRWrite, Exc, EStatus
    );
endinterface

// File: rtl/multicycle_maindec.sv
// LEGv8 multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// data-memory timeout, maskable interrupt and exception/ERET handling.
module multicycle_maindec #(
    parameter int unsigned OP_W        = 11,
    parameter int unsigned ES_W        = 4,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned IRQ_EN      = 1
) (
    input logic                clk,
    input logic                reset,
    multicycle_maindec_if.slave bus
);
    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StExc} state_e;
    typedef enum logic [2:0] {ClsLdur, ClsStur, ClsCbz, ClsRtype, ClsEret, ClsMrs} cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, dec_cls;
    logic              dec_valid;
    logic [ES_W-1:0]   estatus_q, estatus_d;
    logic              mask_q, mask_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        cause_q, cause_d;
    logic [10:0]       opc;

    logic              reg2loc, memtoreg, regwrite, memread, memwrite, branch;
    logic              eret, pcwrite, irwrite, exc, commit, timeout_hit;
    logic [1:0]        alusrc, aluop;

    assign opc         = bus.Op[OP_W-1 -: 11];
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_comb begin
        dec_valid = 1'b1;
        dec_cls   = ClsRtype;
        casez (opc)
            11'b11111000010: dec_cls = ClsLdur;
            11'b11111000000: dec_cls = ClsStur;
            11'b10110100???: dec_cls = ClsCbz;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: dec_cls = ClsRtype;
            11'b11010110100: dec_cls = ClsEret;
            11'b11010101001: dec_cls = ClsMrs;
            default:         dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        estatus_d = estatus_q;
        mask_d    = mask_q;
        cnt_d     = '0;
        cause_d   = cause_q;
        commit    = 1'b0;
        reg2loc   = 1'b0;
        alusrc    = 2'b00;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        branch    = 1'b0;
        aluop     = 2'b00;
        eret      = 1'b0;
        pcwrite   = 1'b0;
        irwrite   = 1'b0;
        exc       = 1'b0;

        case (state_q)
            StFetch: begin
                irwrite = bus.imem_ready;
                pcwrite = bus.imem_ready;
                if (bus.imem_ready) state_d = StDecode;
            end
            StDecode: begin
                cls_d = dec_cls;
                if (dec_valid) begin
                    state_d = StExec;
                end else begin
                    state_d = StExc;
                    cause_d = 4'b0010;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsLdur: begin
                        alusrc  = 2'b01;
                        state_d = StMem;
                    end
                    ClsStur: begin
                        reg2loc = 1'b1;
                        alusrc  = 2'b01;
                        state_d = StMem;
                    end
                    ClsCbz: begin
                        reg2loc = 1'b1;
                        aluop   = 2'b01;
                        branch  = 1'b1;
                        commit  = 1'b1;
                    end
                    ClsMrs: begin
                        alusrc  = 2'b10;
                        aluop   = 2'b01;
                        state_d = StWb;
                    end
                    ClsEret: begin
                        eret      = 1'b1;
                        pcwrite   = 1'b1;
                        estatus_d = '0;
                        mask_d    = 1'b0;
                        commit    = 1'b1;
                    end
                    default: begin
                        aluop   = 2'b10;
                        state_d = StWb;
                    end
                endcase
            end
            StMem: begin
                alusrc = 2'b01;
                if (cls_q == ClsStur) begin
                    reg2loc  = 1'b1;
                    memwrite = 1'b1;
                end else begin
                    memread  = 1'b1;
                end
                // mem_ready outranks a timeout landing in the same cycle
                if (bus.mem_ready) begin
                    if (cls_q == ClsStur) commit = 1'b1;
                    else                  state_d = StWb;
                end else if (timeout_hit) begin
                    state_d = StExc;
                    cause_d = 4'b0011;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWb: begin
                regwrite = 1'b1;
                commit   = 1'b1;
                case (cls_q)
                    ClsLdur: begin
                        memtoreg = 1'b1;
                        alusrc   = 2'b01;
                    end
                    ClsMrs: begin
                        alusrc = 2'b10;
                        aluop  = 2'b01;
                    end
                    default: aluop = 2'b10;
                endcase
            end
            StExc: begin
                exc       = 1'b1;
                pcwrite   = 1'b1;
                estatus_d = ES_W'(cause_q);
                mask_d    = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // mask_d already reflects an ERET clear, so a pending irq is taken at ERET commit
        if (commit) begin
            if ((IRQ_EN != 0) && bus.irq && !mask_d) begin
                state_d = StExc;
                cause_d = 4'b0001;
            end else begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            cls_q     <= ClsLdur;
            estatus_q <= '0;
            mask_q    <= 1'b0;
            cnt_q     <= '0;
            cause_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            estatus_q <= estatus_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
        end
    end

    // Outputs are forced low for the whole time reset is held, not just at the next edge
    assign bus.Reg2Loc  = reset & reg2loc;
    assign bus.ALUSrc   = reset ? alusrc : 2'b00;
    assign bus.MemtoReg = reset & memtoreg;
    assign bus.RegWrite = reset & regwrite;
    assign bus.MemRead  = reset & memread;
    assign bus.MemWrite = reset & memwrite;
    assign bus.Branch   = reset & branch;
    assign bus.ALUOp    = reset ? aluop : 2'b00;
    assign bus.ERet     = reset & eret;
    assign bus.PCWrite  = reset & pcwrite;
    assign bus.IRWrite  = reset & irwrite;
    assign bus.Exc      = reset & exc;
    assign bus.EStatus  = estatus_q;
endmodule
